// File: rtl/bsg_cache_non_blocking_dma_responder.sv
// DMA responder for the non-blocking cache: serves block fills from a simple
// one-cycle-latency word memory and writes evicted blocks back to it.
module bsg_cache_non_blocking_dma_responder #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int mem_addr_width_p      = 15
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [addr_width_p:0]       dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,

  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_i,

  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o,

  output logic                        mem_v_o,
  output logic                        mem_w_o,
  output logic [mem_addr_width_p-1:0] mem_addr_o,
  output logic [data_width_p-1:0]     mem_data_o,
  input  logic [data_width_p-1:0]     mem_data_i
);

  localparam int lg_block_lp = $clog2(block_size_in_words_p);
  localparam int byte_sel_lp = $clog2(data_width_p / 8);
  localparam logic [mem_addr_width_p-1:0] blk_mask_lp =
    mem_addr_width_p'(block_size_in_words_p - 1);
  localparam logic [lg_block_lp-1:0] last_lp = lg_block_lp'(block_size_in_words_p - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e                      r_state;
  state_e                      w_state_n;
  logic [mem_addr_width_p-1:0] r_base;
  logic [lg_block_lp-1:0]      r_cnt;         // next word to issue (read) or write
  logic                        r_all_issued;
  logic [lg_block_lp-1:0]      r_rcv_cnt;     // fill words handed to the cache
  logic                        r_inflight;    // read issued last cycle, data on mem_data_i now
  logic [1:0]                  r_fifo_cnt;
  logic [data_width_p-1:0]     r_fifo [2];

  logic [mem_addr_width_p-1:0] w_pkt_word;
  logic [1:0]                  w_occ;
  logic [1:0]                  w_fifo_cnt_n;
  logic                        w_take;
  logic                        w_unused;

  assign w_pkt_word = dma_pkt_i[byte_sel_lp +: mem_addr_width_p];
  assign w_unused   = ^dma_pkt_i;
  assign w_occ      = r_fifo_cnt + {1'b0, r_inflight};

  assign mem_addr_o = r_base | {{(mem_addr_width_p - lg_block_lp){1'b0}}, r_cnt};
  assign mem_data_o = dma_data_i;

  // The arriving read word bypasses an empty FIFO so the first word shows up
  // the cycle after its read; if not taken it is captured and replayed as-is.
  assign dma_data_o = (r_fifo_cnt != 2'd0) ? r_fifo[0] : mem_data_i;
  assign w_take     = dma_data_v_o & dma_data_ready_i;

  // NOTE: every output and w_state_n gets a default first so no latch is inferred.
  always_comb begin
    w_state_n       = r_state;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_v_o    = 1'b0;
    dma_data_yumi_o = 1'b0;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;

    unique case (r_state)
      IDLE: begin
        dma_pkt_yumi_o = dma_pkt_v_i & ~reset_i;
        if (dma_pkt_yumi_o) begin
          w_state_n = dma_pkt_i[addr_width_p] ? WRITE : READ;
        end
      end

      READ: begin
        mem_v_o      = ~r_all_issued & (w_occ < 2'd2);
        dma_data_v_o = (r_fifo_cnt != 2'd0) | r_inflight;
        if (dma_data_v_o & dma_data_ready_i & (r_rcv_cnt == last_lp)) begin
          w_state_n = IDLE;
        end
      end

      WRITE: begin
        dma_data_yumi_o = dma_data_v_i;
        mem_v_o         = dma_data_v_i;
        mem_w_o         = 1'b1;
        if (dma_data_v_i & (r_cnt == last_lp)) begin
          w_state_n = IDLE;
        end
      end

      default: w_state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_cnt        <= '0;
      r_all_issued <= 1'b0;
      r_rcv_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_fifo_cnt   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_inflight <= mem_v_o & ~mem_w_o;
      r_fifo_cnt <= w_fifo_cnt_n;

      if (dma_pkt_yumi_o) begin
        r_base       <= w_pkt_word & ~blk_mask_lp;
        r_cnt        <= '0;
        r_all_issued <= 1'b0;
        r_rcv_cnt    <= '0;
      end else begin
        if (mem_v_o) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == last_lp) begin
            r_all_issued <= 1'b1;
          end
        end
        if (w_take) begin
          r_rcv_cnt <= r_rcv_cnt + 1'b1;
        end
      end
    end
  end

  // Logical queue = stored entries followed by the arriving word (if any).
  assign w_fifo_cnt_n = r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_take};

  // NOTE: FIFO storage has no reset; r_fifo_cnt alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_take) begin
      if (r_fifo_cnt == 2'd2) begin
        r_fifo[0] <= r_fifo[1];
      end else if ((r_fifo_cnt == 2'd1) && r_inflight) begin
        r_fifo[0] <= mem_data_i;
      end
    end else if (r_inflight) begin
      if (r_fifo_cnt == 2'd0) begin
        r_fifo[0] <= mem_data_i;
      end else begin
        r_fifo[1] <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_bsg_cache_non_blocking_dma_responder.sv
// Scoreboard bench: stimulus pushes expected fill words / memory writes,
// a negedge monitor pops and compares whatever the responder produces.
module tb_bsg_cache_non_blocking_dma_responder;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BS  = 8;
  localparam int MAW = 15;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [AW:0]   dma_pkt_i;
  logic          dma_pkt_v_i;
  logic          dma_pkt_yumi_o;
  logic [DW-1:0] dma_data_o;
  logic          dma_data_v_o;
  logic          dma_data_ready_i;
  logic [DW-1:0] dma_data_i;
  logic          dma_data_v_i;
  logic          dma_data_yumi_o;
  logic          mem_v_o;
  logic          mem_w_o;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;

  bsg_cache_non_blocking_dma_responder #(
    .addr_width_p(AW), .data_width_p(DW),
    .block_size_in_words_p(BS), .mem_addr_width_p(MAW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  typedef struct packed {
    logic [MAW-1:0] a;
    logic [DW-1:0]  d;
  } wr_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mem_model [2**MAW];
  logic [DW-1:0] ref_mem   [2**MAW];
  logic [DW-1:0] exp_fill [$];
  wr_t           exp_wr   [$];

  int ready_mode = 0;
  int fills_done = 0;
  int first_fill_cyc = 0;
  int last_fill_cyc  = 0;
  int yumi_cyc = 0;
  int issued = 0;
  int consumed = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  // Backing memory: one-cycle read latency, always accepts.
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) mem_model[mem_addr_o] = mem_data_o;
      else         mem_data_i <= mem_model[mem_addr_o];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  always @(negedge clk_i) begin : mon
    logic [DW-1:0] d;
    wr_t e;
    if (reset_i) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("fill_hold_v", dma_data_v_o, 1'b1);
        check("fill_hold_d", dma_data_o, hold_d);
      end
      hold_v = dma_data_v_o & ~dma_data_ready_i;
      hold_d = dma_data_o;

      if (mem_v_o && !mem_w_o) begin
        check("reads_outstanding_lt2", (issued - consumed) < 2, 1'b1);
        issued++;
      end

      if (dma_data_v_o && dma_data_ready_i) begin
        check("fill_expected", exp_fill.size() != 0, 1'b1);
        if (exp_fill.size() != 0) begin
          d = exp_fill.pop_front();
          check("fill_data", dma_data_o, d);
        end
        if (fills_done == 0) first_fill_cyc = cyc;
        last_fill_cyc = cyc;
        fills_done++;
        consumed++;
      end

      if (dma_data_yumi_o) check("evict_yumi_needs_v", dma_data_v_i, 1'b1);

      if (mem_v_o && mem_w_o) begin
        check("mem_write_expected", exp_wr.size() != 0, 1'b1);
        check("mem_write_with_yumi", dma_data_yumi_o, 1'b1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("mem_write_addr", mem_addr_o, e.a);
          check("mem_write_data", mem_data_o, e.d);
        end
      end

      if (dma_pkt_yumi_o) yumi_cyc = cyc;
    end
  end

  // Fill-side ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  initial begin : ready_drv
    int ph;
    ph = 0;
    dma_data_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        1:       dma_data_ready_i = (ph % 3 == 0);
        2:       dma_data_ready_i = 1'($urandom_range(0, 1));
        default: dma_data_ready_i = 1'b1;
      endcase
      ph++;
    end
  end

  function automatic int blk_base(input logic [AW-1:0] addr);
    return ((int'(addr) / (DW / 8)) % (2**MAW)) / BS * BS;
  endfunction

  task automatic send_pkt(input logic w, input logic [AW-1:0] addr, output int waited);
    dma_pkt_i   = {w, addr};
    dma_pkt_v_i = 1'b1;
    waited      = 0;
    @(negedge clk_i);
    while (!dma_pkt_yumi_o && waited < 50) begin
      waited++;
      @(negedge clk_i);
    end
    check("pkt_yumi", dma_pkt_yumi_o, 1'b1);
    @(posedge clk_i);
    #1;
    dma_pkt_v_i = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int mode, input bit timing,
                         input bit immediate);
    int base, waited, n;
    base = blk_base(addr);
    issued = 0; consumed = 0; fills_done = 0;
    ready_mode = mode;
    for (int i = 0; i < BS; i++) exp_fill.push_back(ref_mem[base + i]);
    send_pkt(1'b0, addr, waited);
    if (immediate) check("pkt_yumi_next_cycle", waited, 0);
    n = 0;
    do begin
      @(posedge clk_i);
      n++;
    end while (exp_fill.size() != 0 && n < 200);
    #1;
    check("read_block_complete", exp_fill.size(), 0);
    exp_fill.delete();
    if (timing) begin
      check("first_fill_latency", first_fill_cyc - yumi_cyc, 2);
      check("fill_burst_span", last_fill_cyc - first_fill_cyc, BS - 1);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data [BS],
                          input int gap_mode);
    int base, waited, gaps;
    wr_t t;
    base = blk_base(addr);
    for (int i = 0; i < BS; i++) begin
      t.a = MAW'(base + i);
      t.d = data[i];
      exp_wr.push_back(t);
      ref_mem[base + i] = data[i];
    end
    send_pkt(1'b1, addr, waited);
    for (int i = 0; i < BS; i++) begin
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        dma_data_v_i = 1'b0;
        dma_data_i   = $urandom;
        @(posedge clk_i);
        #1;
      end
      dma_data_v_i = 1'b1;
      dma_data_i   = data[i];
      @(negedge clk_i);
      check("evict_yumi", dma_data_yumi_o, 1'b1);
      @(posedge clk_i);
      #1;
    end
    dma_data_v_i = 1'b0;
    check("write_block_complete", exp_wr.size(), 0);
    exp_wr.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] wd [BS];
    int n;
    logic [AW-1:0] ra;

    for (int i = 0; i < 2**MAW; i++) begin
      mem_model[i] = DW'(32'h100 + i);
      ref_mem[i]   = DW'(32'h100 + i);
    end
    reset_i = 1'b1;
    dma_pkt_i = '0; dma_pkt_v_i = 1'b0;
    dma_data_i = '0; dma_data_v_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    dma_pkt_v_i = 1'b1;
    #1;
    check("reset_pkt_yumi", dma_pkt_yumi_o, 1'b0);
    check("reset_fill_v", dma_data_v_o, 1'b0);
    check("reset_evict_yumi", dma_data_yumi_o, 1'b0);
    check("reset_mem_v", mem_v_o, 1'b0);
    dma_pkt_v_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Aligned read with ready held high: words 0x110..0x117
    do_read(32'h40, 0, 1'b1, 1'b0);

    // Write with evict valid gapped every other cycle
    for (int i = 0; i < BS; i++) wd[i] = DW'(32'hA0 + i);
    do_write(32'h20, wd, 1);
    for (int i = 0; i < BS; i++) check("mem_after_write", mem_model[8 + i], DW'(32'hA0 + i));

    // Backpressure read of the freshly written block
    do_read(32'h20, 1, 1'b0, 1'b0);

    // Unaligned address lands on block base word 16
    do_read(32'h4C, 0, 1'b1, 1'b0);

    // Back-to-back write then read of the same block
    for (int i = 0; i < BS; i++) wd[i] = $urandom;
    do_write(32'h60, wd, 0);
    do_read(32'h60, 0, 1'b1, 1'b1);

    // Reset in the middle of a read block
    issued = 0; consumed = 0; fills_done = 0; ready_mode = 0;
    for (int i = 0; i < BS; i++) exp_fill.push_back(ref_mem[16 + i]);
    send_pkt(1'b0, 32'h40, n);
    n = 0;
    while (fills_done < 3 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    check("reset_midblock_progress", fills_done, 3);
    #2;
    reset_i = 1'b1;
    dma_pkt_v_i = 1'b1;
    #1;
    check("midreset_fill_v", dma_data_v_o, 1'b0);
    check("midreset_mem_v", mem_v_o, 1'b0);
    check("midreset_pkt_yumi", dma_pkt_yumi_o, 1'b0);
    check("midreset_evict_yumi", dma_data_yumi_o, 1'b0);
    dma_pkt_v_i = 1'b0;
    exp_fill.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    do_read(32'h40, 0, 1'b1, 1'b0);

    // Randomized traffic over the first 256 words
    for (int k = 0; k < 16; k++) begin
      ra = AW'($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < BS; i++) wd[i] = $urandom;
        do_write(ra, wd, 2);
      end else begin
        do_read(ra, 2, 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
